// File: rtl/serial_sub_pkg.sv
// serial_sub_pkg: state encoding and default width shared by the serial subtractor.
package serial_sub_pkg;
    localparam int DEF_W = 4;
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/full_sub1.sv
// full_sub1: 1-bit combinational full subtractor, diff = x - y - bi.
module full_sub1 (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic diff,
    output logic bo
);
    assign diff = x ^ y ^ bi;
    assign bo   = (~x & y) | (~(x ^ y) & bi);
endmodule

// File: rtl/serial_sub.sv
// serial_sub: bit-serial W-bit subtractor d = a - b - bin, LSB first, start/busy/done handshake.
// Defining SERIAL_SUB_OVF_EN adds a registered signed-overflow output ovf.
module serial_sub
    import serial_sub_pkg::*;
#(
    parameter int W  = DEF_W,
    parameter int CW = $clog2(W + 1)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         ovf
`endif
);
    state_t        r_state, w_next;
    logic [W-1:0]  r_sa, r_sb, r_sr, w_sr_nxt;
    logic [CW-1:0] r_cnt;
    logic          r_br, w_x, w_bo, w_last, w_accept;
`ifdef SERIAL_SUB_OVF_EN
    logic          r_am, r_bm;
`endif

    full_sub1 u_fs (.x(r_sa[0]), .y(r_sb[0]), .bi(r_br), .diff(w_x), .bo(w_bo));

    assign w_last   = r_cnt == CW'(W - 1);
    assign w_accept = (r_state == IDLE) && start;
    assign w_sr_nxt = W'({w_x, r_sr} >> 1);
    assign busy     = r_state == SHIFT;
    assign done     = r_state == DONE;

    always_comb begin
        w_next = (r_state == IDLE)  ? (start ? SHIFT : IDLE) :
                 (r_state == SHIFT) ? (w_last ? DONE : SHIFT) : IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    // d/bout only update on the final shift edge so the old result stays visible
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sa  <= '0;
            r_sb  <= '0;
            r_sr  <= '0;
            r_br  <= 1'b0;
            r_cnt <= '0;
            d     <= '0;
            bout  <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_am  <= 1'b0;
            r_bm  <= 1'b0;
            ovf   <= 1'b0;
`endif
        end else if (w_accept) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= bin;
            r_cnt <= '0;
`ifdef SERIAL_SUB_OVF_EN
            r_am  <= a[W-1];
            r_bm  <= b[W-1];
`endif
        end else if (r_state == SHIFT) begin
            r_sa  <= r_sa >> 1;
            r_sb  <= r_sb >> 1;
            r_sr  <= w_sr_nxt;
            r_br  <= w_bo;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                d    <= w_sr_nxt;
                bout <= w_bo;
`ifdef SERIAL_SUB_OVF_EN
                ovf  <= (r_am ^ r_bm) & (r_am ^ w_x);
`endif
            end
        end
    end
endmodule

// File: tb/tb_serial_sub.sv
// tb_serial_sub: directed and random checks of serial_sub against an arithmetic reference model.
module tb_serial_sub;
    localparam int W = 4;
    localparam int MASK = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         bin = 1'b0;
    logic         busy, done, bout;
    logic [W-1:0] d;
    logic         ovf_w;

    int tests = 0;
    int fails = 0;
    int cur_d = 0;
    int cur_bout = 0;
    int cur_ovf = 0;
    longint t_done = 0;
    longint t_first = 0;

    serial_sub #(.W(W)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b), .bin(bin),
        .busy(busy), .done(done), .d(d), .bout(bout)
`ifdef SERIAL_SUB_OVF_EN
        , .ovf(ovf_w)
`endif
    );
`ifndef SERIAL_SUB_OVF_EN
    assign ovf_w = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic int m_d(int x, int y, int bi);
        return (x - y - bi) & MASK;
    endfunction

    function automatic int m_bout(int x, int y, int bi);
        return (x < y + bi) ? 1 : 0;
    endfunction

    function automatic int m_ovf(int x, int y, int bi);
        int sx = (x > MASK / 2) ? x - (MASK + 1) : x;
        int sy = (y > MASK / 2) ? y - (MASK + 1) : y;
        int r  = sx - sy - bi;
`ifdef SERIAL_SUB_OVF_EN
        return (r < -(MASK + 1) / 2 || r > MASK / 2) ? 1 : 0;
`else
        return (r == r) ? 0 : 0;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Caller sits at a negedge with the DUT idle; returns at the negedge after the done cycle.
    task automatic run_op(input int ia, input int ib, input int ibin);
        int ed = m_d(ia, ib, ibin);
        int eb = m_bout(ia, ib, ibin);
        int eo = m_ovf(ia, ib, ibin);
        a = W'(ia); b = W'(ib); bin = 1'(ibin); start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("busy_shift", 32'(busy), 32'd1);
            check("done_shift", 32'(done), 32'd0);
            check("d_held", 32'(d), 32'(cur_d));
            check("bout_held", 32'(bout), 32'(cur_bout));
        end
        @(negedge clk);
        t_done = $time;
        check("done_pulse", 32'(done), 32'd1);
        check("busy_done", 32'(busy), 32'd0);
        check("d", 32'(d), 32'(ed));
        check("bout", 32'(bout), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
        check("ovf", 32'(ovf_w), 32'(eo));
`endif
        cur_d = ed; cur_bout = eb; cur_ovf = eo;
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("busy_idle", 32'(busy), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_d", 32'(d), 32'd0);
        check("rst_bout", 32'(bout), 32'd0);
        check("rst_ovf", 32'(ovf_w), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", 32'(busy), 32'd0);

        run_op(7, 3, 0);
        run_op(3, 7, 0);
        run_op(0, 0, 1);
        run_op(6, 6, 0);

        // start held through a whole op; the second op must wait for IDLE
        a = 4'd9; b = 4'd2; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 4'd1; b = 4'd1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            check("held_busy", 32'(busy), 32'd1);
            check("held_d_keep", 32'(d), 32'(cur_d));
        end
        @(negedge clk);
        t_first = $time;
        check("held_done", 32'(done), 32'd1);
        check("held_d", 32'(d), 32'h7);
        check("held_bout", 32'(bout), 32'd0);
        @(negedge clk);
        check("held_idle_done", 32'(done), 32'd0);
        check("held_idle_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("held_restart", 32'(busy), 32'd1);
        start = 1'b0;
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            check("held2_busy", 32'(busy), 32'd1);
            check("held2_d_keep", 32'(d), 32'h7);
        end
        @(negedge clk);
        check("held2_done", 32'(done), 32'd1);
        check("held2_d", 32'(d), 32'h0);
        check("held2_bout", 32'(bout), 32'd0);
        check("held_spacing", 32'($time - t_first), 32'((W + 2) * 10));
        cur_d = 0; cur_bout = 0;
        @(negedge clk);
        check("held2_done_end", 32'(done), 32'd0);

        run_op(15, 1, 0);
        t_first = t_done;
        run_op(1, 2, 0);
        check("b2b_spacing", 32'(t_done - t_first), 32'((W + 2) * 10));

        // asynchronous reset two edges into SHIFT
        a = 4'd5; b = 4'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_busy_pre", 32'(busy), 32'd1);
        reset = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_d", 32'(d), 32'd0);
        check("abort_bout", 32'(bout), 32'd0);
        check("abort_ovf", 32'(ovf_w), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        cur_d = 0; cur_bout = 0;

        run_op(8, 1, 0);
        run_op(7, 1, 0);

        for (int n = 0; n < 40; n++)
            run_op(int'($urandom_range(MASK, 0)), int'($urandom_range(MASK, 0)), int'($urandom_range(1, 0)));

        // round trip against adder semantics: (a + b) - b == a
        for (int n = 0; n < 8; n++) begin
            int x = int'($urandom_range(MASK, 0));
            int y = int'($urandom_range(MASK, 0));
            run_op((x + y) & MASK, y, 0);
            check("roundtrip", 32'(d), 32'(x));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/serial_sub.md
Name: serial_sub

Overview:
- Bit-serial W-bit full subtractor computing D = A − B − bin, LSB first, one bit per clock.
- Arithmetic inverse of the lab's registered parallel full adder.
- Sits in the same lab datapath as the adder; a bench cross-checks the two (A + B then subtract B must return A).
- Uses a start/busy/done handshake so the result is sampled only when valid.

Parameters:
- W, 4, operand/result width in bits (≥2).
- CW, $clog2(W+1), bit-counter width (derived; do not override).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous, active-high; clears all state.
- start, input, 1, request; sampled only in IDLE.
- a, input, W, minuend; captured when start is accepted.
- b, input, W, subtrahend; captured when start is accepted.
- bin, input, 1, borrow-in; captured when start is accepted.
- busy, output, 1, high while bits are being processed (SHIFT).
- done, output, 1, one-cycle pulse; d and bout are valid from this cycle onward.
- d, output, W, difference; registered; held until the next start is accepted.
- bout, output, 1, borrow-out; registered; held like d.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset values: state=IDLE, busy=0, done=0, d=0, bout=0, shift regs=0, counter=0, borrow FF=0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at an edge: load sa←a, sb←b, br←bin, cnt←0, go to SHIFT.
  - start=0: remain in IDLE.
- SHIFT, each edge:
  - x = sa[0]^sb[0]^br.
  - br ← (~sa[0]&sb[0]) | (~(sa[0]^sb[0])&br).
  - sr ← {x, sr[W-1:1]}; sa and sb shift right; cnt++.
  - On the W-th SHIFT edge: d ← final sr, bout ← final br, go to DONE.
- DONE: done=1 for exactly one cycle, then IDLE at the next edge.
- Latency: start sampled at edge k → busy high from edge k to edge k+W, done high from edge k+W to edge k+W+1. Throughput is one op per W+2 cycles.
- busy = (state==SHIFT). done = (state==DONE). Both are decoded from registered state, so no combinational path from inputs.
- start in SHIFT or DONE is ignored: no queuing, no restart.
- a, b and bin may change freely after acceptance without affecting the result.
- d and bout do not change during SHIFT; the previous result stays visible until the new done.
- Arithmetic is modulo 2^W. bout=1 iff a < b + bin, compared unsigned.
- reset mid-operation: immediate abort, no done pulse, outputs return to 0.
- a=b with bin=0: d=0, bout=0.
- a=0, b=0, bin=1: d=all ones, bout=1.

Optional Feature:
- Macro: SERIAL_SUB_OVF_EN.
- Defined:
  - Extra output port ovf (1 bit, reset 0), registered with d.
  - ovf = two's-complement overflow of signed a − b − bin: (a[W-1]^b[W-1]) & (a[W-1]^d[W-1]).
  - Operand MSBs are latched at acceptance.
- Undefined: no ovf port, no MSB latches; behaviour otherwise identical.

Decomposition:
- Shared package serial_sub_pkg:
  - State encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2.
  - Default width constant.
- Sub-module full_sub1: 1-bit combinational full subtractor (x, y, bi → diff, bo).
  - Instantiated once per datapath.
  - Shared conceptually with the existing full-adder cell.
- Top serial_sub holds the FSM, counter, shift registers and output registers.

Test Plan:
- W=4, a=7, b=3, bin=0, start pulsed → busy for 4 cycles; done pulse 4 cycles after start edge; d=4'h4, bout=0.
- a=3, b=7, bin=0 → d=4'hC, bout=1. a=0, b=0, bin=1 → d=4'hF, bout=1.
- a=9, b=2, start held high through the whole op, then a=1, b=1 driven during SHIFT:
  - Single done with d=4'h7.
  - Second op starts only after return to IDLE; that op gives d=4'h0, bout=0.
- reset pulsed 2 cycles into SHIFT (after a=5, b=1) → done never asserts; busy, d, bout read 0 immediately, before any clock edge.
- Back-to-back ops (a=F, b=1, then a=1, b=2) → d=E/bout=0 is held until the second done, then d=F/bout=1; the two dones are spaced W+2 cycles apart.
- With SERIAL_SUB_OVF_EN:
  - a=8, b=1, bin=0 → d=7, ovf=1.
  - a=7, b=1 → d=6, ovf=0.
